axi_lite_2_apb_multi: RTL and testbench

- AXI4-Lite slave to APB4 master bridge. Fans out to N_SLAVES APB completers through one-hot psel decode.
- Adds per-slave address decode, PSTRB/PPROT pass-through, PSLVERR mapping, a PREADY timeout, and fair read/write arbitration.
- Sits between the AXI-Lite interconnect and the peripheral APB segment. The APB side is compatible with the team's APB master/slave agents.

---
 rtl/axi_lite_2_apb_multi.sv | 178 +++++++++++++++++
 tb/tb_axi_lite_2_apb_multi.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_2_apb_multi.sv
// rtl/axi_lite_2_apb_multi.sv - AXI4-Lite slave to multi-completer APB4 master bridge
module axi_lite_2_apb_multi #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int N_SLAVES      = 4,
  parameter int SLV_ADDR_BITS = 12,
  parameter int TIMEOUT       = 16
) (
  input  logic                           pclk,
  input  logic                           prst,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [ADDR_WIDTH-1:0]          paddr,
  output logic [2:0]                     pprot,
  output logic [N_SLAVES-1:0]            psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [DATA_WIDTH-1:0]          pwdata,
  output logic [DATA_WIDTH/8-1:0]        pstrb,
  input  logic [N_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [N_SLAVES-1:0]            pready,
  input  logic [N_SLAVES-1:0]            pslverr
);

  localparam int IDX_BITS = $clog2(N_SLAVES);
  localparam int IDX_W    = (IDX_BITS == 0) ? 1 : IDX_BITS;
  localparam int CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W:0] N_SL = (IDX_W + 1)'(N_SLAVES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [1:0]            state;
  logic                  last_read;
  logic [IDX_W-1:0]      sel_idx;
  logic [CNT_W-1:0]      wait_cnt;
  logic [1:0]            resp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  grant_wr, grant_rd;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [IDX_W-1:0]      req_idx;
  logic                  req_miss;
  logic                  slv_ready, slv_err;
  logic [DATA_WIDTH-1:0] slv_rdata;

  // last_read set means the write direction holds priority on a tie
  always_comb begin
    grant_wr = (state == S_IDLE) && !prst && awvalid && wvalid && (last_read || !arvalid);
    grant_rd = (state == S_IDLE) && !prst && arvalid && !grant_wr;
    req_addr = grant_wr ? awaddr : araddr;
    req_idx  = (IDX_BITS == 0) ? '0 : IDX_W'(req_addr >> SLV_ADDR_BITS);
    req_miss = ((req_addr >> (SLV_ADDR_BITS + IDX_BITS)) != '0) || ({1'b0, req_idx} >= N_SL);
  end

  always_comb begin
    slv_ready = 1'b0;
    slv_err   = 1'b0;
    slv_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        slv_ready = pready[i];
        slv_err   = pslverr[i];
        slv_rdata = prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign awready = grant_wr;
  assign wready  = grant_wr;
  assign arready = grant_rd;
  assign bresp   = resp_q;
  assign rresp   = resp_q;
  assign rdata   = rdata_q;

  always_ff @(posedge pclk) begin
    if (prst) begin
      state     <= S_IDLE;
      last_read <= 1'b1;
      sel_idx   <= '0;
      wait_cnt  <= '0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= '0;
      bvalid    <= 1'b0;
      rvalid    <= 1'b0;
      paddr     <= '0;
      pprot     <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_wr || grant_rd) begin
            last_read <= grant_rd;
            paddr     <= req_addr;
            pprot     <= grant_wr ? awprot : arprot;
            pwrite    <= grant_wr;
            pwdata    <= grant_wr ? wdata : '0;
            pstrb     <= grant_wr ? wstrb : '0;
            sel_idx   <= req_idx;
            rdata_q   <= '0;
            wait_cnt  <= '0;
            if (req_miss) begin
              resp_q <= RESP_DECERR;
              bvalid <= grant_wr;
              rvalid <= grant_rd;
              state  <= S_RESP;
            end else begin
              psel  <= N_SLAVES'(1) << req_idx;
              state <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (slv_ready) begin
            resp_q  <= slv_err ? RESP_SLVERR : RESP_OKAY;
            if (!pwrite) rdata_q <= slv_rdata;
            psel    <= '0;
            penable <= 1'b0;
            bvalid  <= pwrite;
            rvalid  <= !pwrite;
            state   <= S_RESP;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            // completer never answered: abandon it, later pready is not looked at
            resp_q  <= RESP_SLVERR;
            rdata_q <= '0;
            psel    <= '0;
            penable <= 1'b0;
            bvalid  <= pwrite;
            rvalid  <= !pwrite;
            state   <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if ((bvalid && bready) || (rvalid && rready)) begin
            bvalid <= 1'b0;
            rvalid <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_2_apb_multi.sv
// tb/tb_axi_lite_2_apb_multi.sv - directed scoreboard bench for axi_lite_2_apb_multi
module tb_axi_lite_2_apb_multi;

  logic         pclk = 1'b0;
  logic         prst;
  logic [31:0]  awaddr, wdata, araddr, rdata, paddr, pwdata;
  logic [2:0]   awprot, arprot, pprot;
  logic [3:0]   wstrb, pstrb, psel, pready, pslverr;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready, penable, pwrite;
  logic [1:0]   bresp, rresp;
  logic [127:0] prdata;

  always #5 pclk = ~pclk;

  axi_lite_2_apb_multi dut (
    .pclk(pclk), .prst(prst),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // APB completer model: ready after wait_cfg ACCESS cycles
  int          wait_cfg = 0;
  int          acc_cnt = 0;
  logic [3:0]  err_cfg = 4'h0;
  logic [3:0]  pulse = 4'h0;
  logic [31:0] slv_data [4];

  always @(posedge pclk) acc_cnt <= penable ? acc_cnt + 1 : 0;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      prdata[i*32 +: 32] = slv_data[i];
      pready[i]  = (psel[i] && penable && (acc_cnt >= wait_cfg)) || pulse[i];
      pslverr[i] = err_cfg[i] && psel[i];
    end
  end

  int         sel_cyc = 0, en_cyc = 0, aw_cyc = 0, ar_cyc = 0;
  logic [3:0] last_psel, last_pstrb;
  logic [31:0] last_pwdata, last_paddr;
  logic       last_pwrite;

  always @(negedge pclk) begin
    if (|psel) sel_cyc++;
    if (awready) aw_cyc++;
    if (arready) ar_cyc++;
    if (penable) begin
      en_cyc++;
      last_psel   = psel;
      last_pstrb  = pstrb;
      last_pwdata = pwdata;
      last_paddr  = paddr;
      last_pwrite = pwrite;
    end
  end

  typedef struct {
    bit          is_wr;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic push(input bit is_wr, input logic [1:0] resp, input logic [31:0] data);
    exp_t e;
    e.is_wr = is_wr;
    e.resp  = resp;
    e.data  = data;
    sb.push_back(e);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    awaddr = a; wdata = d; wstrb = s; awprot = 3'b010;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    @(negedge pclk);
    while (!(awready && wready) && n < 50) begin @(negedge pclk); n++; end
    check("aw_accept", {awready, wready}, 2'b11);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a);
    int n;
    araddr = a; arprot = 3'b001; arvalid = 1'b1;
    n = 0;
    @(negedge pclk);
    while (!arready && n < 50) begin @(negedge pclk); n++; end
    check("ar_accept", arready, 1'b1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic check_item(input string tag, input exp_t e);
    if (e.is_wr) check({tag, "_b"}, {bvalid, rvalid, bresp}, {2'b10, e.resp});
    else check({tag, "_r"}, {bvalid, rvalid, rresp, rdata}, {2'b01, e.resp, e.data});
  endtask

  task automatic wait_resp(input string tag, input int exp_edges, input int hold, input logic [3:0] pmask);
    int k;
    exp_t e;
    k = 0;
    while (!(bvalid || rvalid) && k < 200) begin tick(); k++; end
    check({tag, "_latency"}, k, exp_edges);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check_item(tag, e);
    for (int h = 0; h < hold; h++) begin
      pulse = (h == 0) ? pmask : 4'h0;
      tick();
      check_item({tag, "_hold"}, e);
      check({tag, "_hold_idle"}, {psel, penable}, 5'b0);
    end
    pulse = 4'h0;
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    check({tag, "_done"}, {bvalid, rvalid}, 2'b00);
  endtask

  int s0, e0, a0, r0;

  initial begin
    slv_data[0] = 32'h0BAD_F00D;
    slv_data[1] = 32'h1111_1111;
    slv_data[2] = 32'hCAFE_BABE;
    slv_data[3] = 32'h3333_3333;
    prst = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; awprot = '0; araddr = '0; arprot = '0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;

    tick(); tick();
    check("rst_ready", {awready, wready, arready}, 3'b000);
    check("rst_apb", {psel, penable, pwrite, pstrb, paddr}, '0);
    check("rst_axi", {bvalid, rvalid, bresp, rresp, rdata}, '0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    prst = 1'b0;
    tick();

    // zero-wait write to slave 1
    s0 = sel_cyc; e0 = en_cyc;
    push(1'b1, 2'b00, 32'h0);
    axi_write(32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
    wait_resp("wr1", 2, 0, 4'h0);
    check("wr1_psel_cyc", sel_cyc - s0, 2);
    check("wr1_apb", {last_psel, last_pwrite, last_pstrb, last_pwdata, last_paddr},
          {4'b0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0000_1004});

    // read from slave 2 with 3 wait states
    wait_cfg = 3;
    s0 = sel_cyc; e0 = en_cyc;
    push(1'b0, 2'b00, 32'hCAFE_BABE);
    axi_read(32'h0000_2008);
    wait_resp("rd2", 5, 0, 4'h0);
    check("rd2_penable_cyc", en_cyc - e0, 4);
    check("rd2_apb", {last_psel, last_pwrite, last_pstrb, last_paddr},
          {4'b0100, 1'b0, 4'h0, 32'h0000_2008});
    wait_cfg = 0;

    // decode miss: no APB traffic
    s0 = sel_cyc;
    push(1'b0, 2'b11, 32'h0);
    axi_read(32'h0001_0000);
    wait_resp("miss", 0, 0, 4'h0);
    check("miss_psel_cyc", sel_cyc - s0, 0);

    // PREADY timeout on slave 3, then a late pready pulse
    wait_cfg = 1000;
    s0 = sel_cyc; e0 = en_cyc;
    push(1'b1, 2'b10, 32'h0);
    axi_write(32'h0000_3000, 32'h5555_AAAA, 4'hF);
    wait_resp("tmo", 17, 2, 4'b1000);
    check("tmo_penable_cyc", en_cyc - e0, 16);
    check("tmo_psel", last_psel, 4'b1000);
    wait_cfg = 0;

    // arbitration with all valids held high after reset
    prst = 1'b1; tick(); prst = 1'b0;
    awaddr = 32'h0000_0010; wdata = 32'h1234_5678; wstrb = 4'hF;
    araddr = 32'h0000_0020;
    bready = 1'b1; rready = 1'b1;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    a0 = aw_cyc; r0 = ar_cyc;
    for (int t = 0; t < 4; t++) begin
      int n;
      exp_t e;
      n = 0;
      @(negedge pclk);
      while (!(awready || arready) && n < 50) begin @(negedge pclk); n++; end
      check("arb_grant", {awready, arready}, (t % 2 == 0) ? 2'b10 : 2'b01);
      if (t % 2 == 0) push(1'b1, 2'b00, 32'h0);
      else push(1'b0, 2'b00, 32'h0BAD_F00D);
      n = 0;
      while (!(bvalid || rvalid) && n < 50) begin @(negedge pclk); n++; end
      e = sb.pop_front();
      check_item("arb", e);
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    tick();
    check("arb_aw_pulses", aw_cyc - a0, 2);
    check("arb_ar_pulses", ar_cyc - r0, 2);

    // pslverr on slave 0 with bready stalled
    err_cfg = 4'b0001;
    push(1'b1, 2'b10, 32'h0);
    axi_write(32'h0000_0004, 32'h0000_BEEF, 4'h3);
    wait_resp("err", 2, 5, 4'h0);
    check("err_pstrb", last_pstrb, 4'h3);
    err_cfg = 4'h0;

    // reset in the middle of ACCESS aborts the transfer
    wait_cfg = 1000;
    axi_write(32'h0000_0008, 32'h0F0F_0F0F, 4'hF);
    tick(); tick();
    check("abort_access", {psel, penable}, 5'b00011);
    prst = 1'b1;
    tick();
    check("abort_outputs", {psel, penable, pwrite, pstrb, paddr, pwdata}, '0);
    check("abort_axi", {bvalid, rvalid, awready, arready}, 4'b0);
    prst = 1'b0;
    wait_cfg = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_resp", {bvalid, rvalid, psel}, 6'b0);
    end
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
